// File: rtl/toggle_meter_pkg.sv
// rtl/toggle_meter_pkg.sv - shared constants and state encodings for the toggle power meter
package toggle_meter_pkg;

    localparam int E_TOGGLE_DEF = 375;
    localparam int CNT_W_DEF    = 16;
    localparam int E_W_DEF      = 32;

    typedef enum logic {
        MON_IDLE = 1'b0,
        MON_RUN  = 1'b1
    } mon_state_t;

    typedef enum logic {
        RPT_EMPTY = 1'b0,
        RPT_FULL  = 1'b1
    } rpt_state_t;

endpackage

// File: rtl/popcount.sv
// rtl/popcount.sv - combinational population count of a bit vector
module popcount #(
    parameter  int N_BITS = 4,
    localparam int PC_W   = $clog2(N_BITS + 1)
) (
    input  logic [N_BITS-1:0] bits,
    output logic [PC_W-1:0]   count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < N_BITS; i++) begin
            count = count + PC_W'(bits[i]);
        end
    end

endmodule

// File: rtl/toggle_power_meter.sv
// rtl/toggle_power_meter.sv - windowed toggle counter with energy report and one-deep output slot
module toggle_power_meter
    import toggle_meter_pkg::*;
#(
    parameter int N_BITS   = 4,
    parameter int WINDOW   = 16,
    parameter int E_TOGGLE = E_TOGGLE_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int E_W      = E_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [N_BITS-1:0] mon,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [CNT_W-1:0]  out_toggles,
    output logic [E_W-1:0]    out_energy,
    output logic              overrun
);

    localparam int PC_W  = $clog2(N_BITS + 1);
    localparam int WIN_W = $clog2(WINDOW);
    localparam int SUM_W = CNT_W + PC_W;
    // Product is wide enough that any bit above E_W means saturation
    localparam int P_W   = (CNT_W + 32 > E_W) ? CNT_W + 32 : E_W + 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

    mon_state_t mon_state, mon_next;
    rpt_state_t rpt_state, rpt_next;

    logic [N_BITS-1:0] prev;
    logic [N_BITS-1:0] diff;
    logic [CNT_W-1:0]  acc;
    logic [WIN_W-1:0]  win_cnt;
    logic [PC_W-1:0]   pc;
    logic [SUM_W-1:0]  sum;
    logic [CNT_W-1:0]  sum_sat;
    logic [P_W-1:0]    prod;
    logic [E_W-1:0]    energy_sat;
    logic              close;
    logic              load;

    assign diff = mon ^ prev;

    popcount #(.N_BITS(N_BITS)) u_popcount (
        .bits  (diff),
        .count (pc)
    );

    always_comb begin
        sum        = SUM_W'(acc) + SUM_W'(pc);
        sum_sat    = (sum[SUM_W-1:CNT_W] != '0) ? '1 : sum[CNT_W-1:0];
        prod       = P_W'(sum_sat) * P_W'(E_TOGGLE);
        energy_sat = (prod[P_W-1:E_W] != '0) ? '1 : prod[E_W-1:0];
    end

    assign close     = (mon_state == MON_RUN) && en && (win_cnt == WIN_LAST);
    assign load      = close && ((rpt_state == RPT_EMPTY) || out_ready);
    assign out_valid = (rpt_state == RPT_FULL);

    always_ff @(posedge clk) begin
        if (reset) begin
            mon_state <= MON_IDLE;
            rpt_state <= RPT_EMPTY;
        end else begin
            mon_state <= mon_next;
            rpt_state <= rpt_next;
        end
    end

    always_comb begin
        mon_next = mon_state;
        case (mon_state)
            MON_IDLE: if (en)  mon_next = MON_RUN;
            MON_RUN:  if (!en) mon_next = MON_IDLE;
            default:  mon_next = MON_IDLE;
        endcase
    end

    always_comb begin
        rpt_next = rpt_state;
        case (rpt_state)
            RPT_EMPTY: if (close) rpt_next = RPT_FULL;
            RPT_FULL:  if (out_ready && !close) rpt_next = RPT_EMPTY;
            default:   rpt_next = RPT_EMPTY;
        endcase
    end

    // prev tracks mon on every enabled cycle; the arming cycle only loads it
    always_ff @(posedge clk) begin
        if (reset) begin
            prev    <= '0;
            acc     <= '0;
            win_cnt <= '0;
        end else if (en) begin
            prev <= mon;
            if (mon_state == MON_RUN) begin
                if (close) begin
                    acc     <= '0;
                    win_cnt <= '0;
                end else begin
                    acc     <= sum_sat;
                    win_cnt <= win_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_toggles <= '0;
            out_energy  <= '0;
            overrun     <= 1'b0;
        end else begin
            if (load) begin
                out_toggles <= sum_sat;
                out_energy  <= energy_sat;
            end
            if (close && !load) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_toggle_power_meter.sv
// tb/tb_toggle_power_meter.sv - randomized and directed bench for toggle_power_meter
module tb_toggle_power_meter;

    localparam int     WINDOW  = 16;
    localparam int     E_TOG   = 375;
    localparam int     CNT_MAX = 65535;
    localparam longint E_MAX   = 64'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset, en, out_ready;
    logic [3:0]  mon;
    logic        out_valid, overrun;
    logic [15:0] out_toggles;
    logic [31:0] out_energy;
    logic        sat_valid, sat_overrun;
    logic [3:0]  sat_toggles;
    logic [31:0] sat_energy;

    int vectors     = 0;
    int miscompares = 0;

    // Transaction-level reference: armed flag, window sum/length, one report slot
    bit         m_armed, m_valid, m_ovr;
    int         m_cnt, m_acc, m_tog;
    logic [3:0] m_prev;
    longint     m_energy;

    always #5 clk = ~clk;

    toggle_power_meter dut (
        .clk(clk), .reset(reset), .en(en), .mon(mon), .out_ready(out_ready),
        .out_valid(out_valid), .out_toggles(out_toggles), .out_energy(out_energy),
        .overrun(overrun)
    );

    toggle_power_meter #(.WINDOW(8), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .en(en), .mon(mon), .out_ready(out_ready),
        .out_valid(sat_valid), .out_toggles(sat_toggles), .out_energy(sat_energy),
        .overrun(sat_overrun)
    );

    task automatic model_tick();
        int  pc, rep;
        bit  close, accept;
        if (reset) begin
            m_armed = 0; m_valid = 0; m_ovr = 0;
            m_cnt = 0; m_acc = 0; m_tog = 0; m_prev = '0; m_energy = 0;
        end else begin
            close  = m_armed && en && (m_cnt == WINDOW - 1);
            pc     = $countones(mon ^ m_prev);
            rep    = (m_acc + pc > CNT_MAX) ? CNT_MAX : m_acc + pc;
            accept = m_valid && out_ready;
            if (close) begin
                if (!m_valid || accept) begin
                    m_valid  = 1;
                    m_tog    = rep;
                    m_energy = (longint'(rep) * E_TOG > E_MAX) ? E_MAX : longint'(rep) * E_TOG;
                end else begin
                    m_ovr = 1;
                end
            end else if (accept) begin
                m_valid = 0;
            end
            if (!m_armed) begin
                if (en) begin m_armed = 1; m_prev = mon; end
            end else if (en) begin
                m_prev = mon;
                if (close) begin m_acc = 0; m_cnt = 0; end
                else begin m_acc = rep; m_cnt++; end
            end else begin
                m_armed = 0;
            end
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [3:0] m, input logic rd);
        reset = r; en = e; mon = m; out_ready = rd;
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 4'h0, 0);
        step(1, 0, 4'h0, 0);
        vectors++;
        if ({out_valid, overrun} !== 2'b00) begin
            miscompares++; $display("FAIL reset_flags: valid/overrun got %b required 00", {out_valid, overrun});
        end
        vectors++;
        if (out_toggles !== 16'd0 || out_energy !== 32'd0) begin
            miscompares++; $display("FAIL reset_data: toggles %0d energy %0d required 0 0", out_toggles, out_energy);
        end
    endtask

    task automatic test_basic();
        step(1, 0, 4'h0, 1);
        step(0, 1, 4'h0, 1);
        step(0, 1, 4'h0, 1);
        for (int i = 2; i <= 16; i++) begin
            step(0, 1, (i % 2 == 0) ? 4'hF : 4'h0, 1);
            if (i == 15) begin
                vectors++;
                if (out_valid !== 1'b0) begin
                    miscompares++; $display("FAIL basic_early: out_valid got %b required 0", out_valid);
                end
            end
        end
        vectors++;
        if (out_valid !== 1'b1 || out_toggles !== 16'd60) begin
            miscompares++; $display("FAIL basic_tog: valid %b toggles %0d required 1 60", out_valid, out_toggles);
        end
        vectors++;
        if (out_energy !== 32'd22500) begin
            miscompares++; $display("FAIL basic_energy: got %0d required 22500", out_energy);
        end
    endtask

    task automatic test_pause();
        logic [3:0] m, last;
        int exp_t = 0;
        step(1, 0, 4'h0, 1);
        m = 4'($urandom()); step(0, 1, m, 1); last = m;
        for (int i = 0; i < 6; i++) begin
            m = 4'($urandom()); exp_t += $countones(m ^ last); last = m; step(0, 1, m, 1);
        end
        for (int i = 0; i < 5; i++) begin
            m = 4'($urandom()); step(0, 0, m, 1);
        end
        m = ~last; step(0, 1, m, 1); last = m;
        for (int i = 0; i < 10; i++) begin
            m = 4'($urandom()); exp_t += $countones(m ^ last); last = m; step(0, 1, m, 1);
            if (i == 8) begin
                vectors++;
                if (out_valid !== 1'b0) begin
                    miscompares++; $display("FAIL pause_early: out_valid got %b required 0", out_valid);
                end
            end
        end
        vectors++;
        if (out_valid !== 1'b1 || out_toggles !== 16'(exp_t) || out_energy !== 32'(exp_t * E_TOG)) begin
            miscompares++;
            $display("FAIL pause_report: valid %b toggles %0d energy %0d required 1 %0d %0d",
                     out_valid, out_toggles, out_energy, exp_t, exp_t * E_TOG);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] m, last;
        int t1 = 0;
        step(1, 0, 4'h0, 0);
        m = 4'($urandom()); step(0, 1, m, 0); last = m;
        for (int i = 0; i < 16; i++) begin
            m = 4'($urandom()); t1 += $countones(m ^ last); last = m; step(0, 1, m, 0);
        end
        vectors++;
        if (out_valid !== 1'b1 || out_toggles !== 16'(t1) || overrun !== 1'b0) begin
            miscompares++; $display("FAIL bp_first: valid %b toggles %0d overrun %b required 1 %0d 0",
                                    out_valid, out_toggles, overrun, t1);
        end
        for (int i = 0; i < 16; i++) begin
            m = 4'($urandom() | 32'h1); last = last ^ m; step(0, 1, last, 0);
            if (i < 15) begin
                vectors++;
                if (out_valid !== 1'b1 || out_toggles !== 16'(t1)) begin
                    miscompares++; $display("FAIL bp_hold: cycle %0d valid %b toggles %0d required 1 %0d",
                                            i, out_valid, out_toggles, t1);
                end
            end
        end
        vectors++;
        if (overrun !== 1'b1 || out_toggles !== 16'(t1) || out_energy !== 32'(t1 * E_TOG)) begin
            miscompares++; $display("FAIL bp_overrun: overrun %b toggles %0d energy %0d required 1 %0d %0d",
                                    overrun, out_toggles, out_energy, t1, t1 * E_TOG);
        end
        step(0, 0, 4'h0, 1);
        vectors++;
        if (out_valid !== 1'b0 || overrun !== 1'b1) begin
            miscompares++; $display("FAIL bp_drain: valid %b overrun %b required 0 1", out_valid, overrun);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] m, last;
        int ta = 0, tb = 0;
        step(1, 0, 4'h0, 0);
        m = 4'($urandom()); step(0, 1, m, 0); last = m;
        for (int i = 0; i < 16; i++) begin
            m = 4'($urandom()); ta += $countones(m ^ last); last = m; step(0, 1, m, 0);
        end
        for (int i = 0; i < 16; i++) begin
            m = 4'($urandom()); tb += $countones(m ^ last); last = m; step(0, 1, m, (i == 15) ? 1'b1 : 1'b0);
            vectors++;
            if (out_valid !== 1'b1) begin
                miscompares++; $display("FAIL b2b_gap: cycle %0d out_valid got %b required 1", i, out_valid);
            end
        end
        vectors++;
        if (out_toggles !== 16'(tb) || out_energy !== 32'(tb * E_TOG) || overrun !== 1'b0) begin
            miscompares++; $display("FAIL b2b_data: toggles %0d energy %0d overrun %b required %0d %0d 0 (first was %0d)",
                                    out_toggles, out_energy, overrun, tb, tb * E_TOG, ta);
        end
        step(0, 0, 4'h0, 1);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL b2b_drain: out_valid got %b required 0", out_valid);
        end
    endtask

    task automatic test_saturation();
        step(1, 0, 4'h0, 1);
        step(0, 1, 4'h0, 1);
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, (i % 2 == 1) ? 4'hF : 4'h0, 1);
            if (i == 7) begin
                vectors++;
                if (sat_valid !== 1'b0) begin
                    miscompares++; $display("FAIL sat_early: sat valid got %b required 0", sat_valid);
                end
            end
        end
        vectors++;
        if (sat_valid !== 1'b1 || sat_toggles !== 4'd15 || sat_energy !== 32'd5625) begin
            miscompares++; $display("FAIL sat_report: valid %b toggles %0d energy %0d required 1 15 5625",
                                    sat_valid, sat_toggles, sat_energy);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] m, last;
        int t = 0;
        step(1, 0, 4'h0, 0);
        step(0, 1, 4'h3, 0);
        for (int i = 0; i < 26; i++) step(0, 1, 4'($urandom()), 0);
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++; $display("FAIL rst_pre: out_valid got %b required 1", out_valid);
        end
        step(1, 1, 4'($urandom()), 0);
        vectors++;
        if ({out_valid, overrun} !== 2'b00 || out_toggles !== 16'd0 || out_energy !== 32'd0) begin
            miscompares++; $display("FAIL rst_mid: valid %b overrun %b toggles %0d energy %0d required all 0",
                                    out_valid, overrun, out_toggles, out_energy);
        end
        m = 4'($urandom()); step(0, 1, m, 0); last = m;
        for (int i = 0; i < 16; i++) begin
            m = 4'($urandom()); t += $countones(m ^ last); last = m; step(0, 1, m, 0);
            if (i == 14) begin
                vectors++;
                if (out_valid !== 1'b0) begin
                    miscompares++; $display("FAIL rst_early: out_valid got %b required 0", out_valid);
                end
            end
        end
        vectors++;
        if (out_valid !== 1'b1 || out_toggles !== 16'(t) || out_energy !== 32'(t * E_TOG)) begin
            miscompares++; $display("FAIL rst_post: valid %b toggles %0d energy %0d required 1 %0d %0d",
                                    out_valid, out_toggles, out_energy, t, t * E_TOG);
        end
    endtask

    task automatic test_random();
        step(1, 0, 4'h0, 0);
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 85),
                 4'($urandom()), ($urandom_range(0, 99) < 40));
            vectors++;
            if (out_valid !== m_valid || overrun !== m_ovr || out_toggles !== 16'(m_tog)
                || 64'(out_energy) !== m_energy) begin
                miscompares++;
                $display("FAIL random: cycle %0d valid %b ovr %b tog %0d energy %0d required %b %b %0d %0d",
                         i, out_valid, overrun, out_toggles, out_energy, m_valid, m_ovr, m_tog, m_energy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pause();
        test_backpressure();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/toggle_power_meter.md
TOGGLE_POWER_METER -- requirements
Module: toggle_power_meter

Interface
REQ-001 The block SHALL have parameter N_BITS, default 4, the width of the monitored gate-output bus.
REQ-002 The block SHALL have parameter WINDOW, default 16, the number of enabled cycles per measurement window (legal range 2..65535).
REQ-003 The block SHALL have parameter E_TOGGLE, default 375, the energy per output toggle in pJ (C_L 15 pF x Vcc^2 25 V^2).
REQ-004 The block SHALL have parameter CNT_W, default 16, the toggle-count width.
REQ-005 The block SHALL have parameter E_W, default 32, the energy width.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port en, input, 1 bit: measurement enable.
REQ-009 The block SHALL have port mon, input, N_BITS bits: gate outputs under measurement, synchronous to clk.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the report.
REQ-011 The block SHALL have port out_valid, output, 1 bit: a report is held.
REQ-012 The block SHALL have port out_toggles, output, CNT_W bits: total toggles in the reported window.
REQ-013 The block SHALL have port out_energy, output, E_W bits: dissipated energy in pJ for the reported window.
REQ-014 The block SHALL have port overrun, output, 1 bit: sticky flag for a dropped report.

Function
REQ-015 The monitor FSM SHALL have states IDLE (unarmed) and RUN (armed).
- IDLE->RUN on en=1: mon is loaded into prev; no toggles are counted that cycle; the window counter does not advance.
- RUN->IDLE on en=0: the accumulator and window counter hold their values; prev is not updated.
REQ-016 In RUN with en=1, each cycle SHALL add popcount(mon ^ prev) to the accumulator, load prev<=mon, and increment the window counter.
REQ-017 The toggle accumulator SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-018 A window SHALL close on the RUN, en=1 cycle in which the window counter equals WINDOW-1.
- On close, the report value is the accumulator plus this cycle's popcount, saturated.
- On close, the accumulator and window counter are cleared for the next cycle.
REQ-019 out_energy SHALL equal out_toggles x E_TOGGLE, saturated at 2^E_W-1, and SHALL be computed at load time, not combinationally on the output.
REQ-020 The report FSM SHALL have states EMPTY and FULL; out_valid SHALL be 1 exactly in FULL.
REQ-021 A report SHALL appear one cycle after window close: out_valid=1, with out_toggles and out_energy registered.
REQ-022 In FULL, out_toggles and out_energy SHALL remain stable until the cycle in which out_valid&&out_ready; FULL->EMPTY on the following edge.
REQ-023 If a window closes in the same cycle as an accepted handshake, the new report SHALL load and out_valid SHALL stay 1 without a gap.
REQ-024 If a window closes while in FULL and no handshake occurs that cycle, the new report SHALL be dropped, the held report SHALL be kept, and overrun SHALL be set to 1 until reset.
REQ-025 out_ready SHALL be ignored in EMPTY.

Reset
REQ-026 On reset=1 at a rising edge, the following SHALL be cleared: FSMs to IDLE/EMPTY; prev, accumulator and window counter to 0; out_valid, out_toggles, out_energy and overrun to 0.
REQ-027 Reset mid-window or mid-handshake SHALL discard all partial and held data; the first report after reset SHALL cover a full WINDOW counted from re-arming.

Structure
REQ-028 Package toggle_meter_pkg SHALL hold the default E_TOGGLE, CNT_W and E_W constants, and the monitor-state and report-state encodings.
REQ-029 Sub-module popcount (N_BITS in, $clog2(N_BITS+1) out, purely combinational) SHALL compute per-cycle toggles.

Verification
REQ-030 The bench SHALL cover basic counting: reset, en=1, mon alternating 4'h0/4'hF each cycle, out_ready=1 -> out_toggles=60 (15 transitions x 4 bits), out_energy=22500, out_valid one cycle after the 16th enabled cycle.
REQ-031 The bench SHALL cover pause: en=0 for 5 cycles mid-window with mon changing -> no toggles counted during the pause or on the re-arm cycle; the window closes after 16 enabled RUN cycles in total.
REQ-032 The bench SHALL cover backpressure and overrun: out_ready=0 across two window closes -> the first report is held unchanged, overrun=1 after the second close; out_ready=1 -> out_valid drops the next cycle.
REQ-033 The bench SHALL cover back-to-back reports: handshake coincident with window close -> out_valid stays 1 and data updates to the new report on the same edge.
REQ-034 The bench SHALL cover saturation: CNT_W=4, WINDOW=8, mon toggling 4 bits/cycle -> out_toggles=15 and out_energy=5625.
REQ-035 The bench SHALL cover reset mid-operation: reset asserted in FULL at cycle 10 of the next window -> all outputs 0 the next cycle; the next report reflects only post-reset activity.
